alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: d_Width, default 8, operand/result width of the shared ALU.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  output  1  requester N's operation accepted this cycle.
REQ-006 reqN_opA, reqN_opB  input  d_Width  requester N operands.
REQ-007 reqN_opcode  input  3  requester N opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 illegal).
REQ-008 respN_valid  output  1  result available for requester N.
REQ-009 respN_ready  input  1  requester N consumes the result.
REQ-010 resp_result  output  d_Width  result, shared by both response ports.
REQ-011 resp_carry, resp_zero, resp_err  output  1 each  captured carry, captured zero, illegal-opcode flag.
REQ-012 alu_opA, alu_opB  output  d_Width  operands to the external ALU.
REQ-013 alu_opcode  output  3  opcode to the external ALU.
REQ-014 alu_result  input  d_Width; alu_carry, alu_zero  input  1  combinational ALU outputs.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 op_count  output  16  number of completed response handshakes.

Function
REQ-017 FSM states: IDLE, EXEC, RESP; only one operation is in flight at any time.
REQ-018 IDLE: if either reqN_valid is high, assert reqN_ready (combinational) for the granted requester only, latch its opA/opB/opcode and id, then move to EXEC.
REQ-019 Grant: a single valid requester wins; with both valid, the requester not granted last wins (round-robin); last_grant updates on acceptance.
REQ-020 reqN_ready is low in EXEC and RESP, and low for the non-granted requester.
REQ-021 EXEC lasts exactly one cycle: alu_opA/alu_opB/alu_opcode drive the latched values; at the clock edge alu_result, alu_carry and alu_zero are captured into the response registers, then the FSM moves to RESP.
REQ-022 alu_* outputs hold the latched values in EXEC and RESP, and the last latched values in IDLE (zero after reset).
REQ-023 Illegal opcode (111): capture resp_result=0, resp_carry=0, resp_zero=0, resp_err=1; ALU outputs are ignored. resp_err=0 for all legal opcodes.
REQ-024 resp_carry is alu_carry passed through unchanged (add carry for every legal opcode); resp_zero is alu_zero unchanged.
REQ-025 RESP: respN_valid is high for the owning requester only; resp_* are stable until the handshake.
REQ-026 Handshake completes when respN_valid and respN_ready are both high; on that edge the FSM moves to IDLE and op_count increments.
REQ-027 respN_ready asserted for the non-owner, or outside RESP, has no effect.
REQ-028 Minimum throughput is one operation per 3 cycles (accept, EXEC, RESP with ready already high); a new grant is possible in the cycle after return to IDLE.
REQ-029 op_count wraps from 16'hFFFF to 0 without any flag.
REQ-030 Requester inputs are sampled only in the acceptance cycle; later changes do not affect the in-flight operation.

Reset
REQ-031 With rst high at a clock edge: state=IDLE, last_grant=1 (requester 0 wins the first tie), resp_result=0, resp_carry=0, resp_zero=0, resp_err=0, alu_opA=0, alu_opB=0, alu_opcode=000, op_count=0, busy=0, and all reqN_ready/respN_valid low.
REQ-032 Reset in EXEC or RESP discards the in-flight operation: no response is issued and op_count does not increment.
REQ-033 reqN_ready is forced low while rst is high.

Verification
REQ-034 d_Width=8, req0 only, add 8'hF0+8'h20: accepted cycle 0; resp0_valid cycle 2 with result 8'h10, carry 1, zero 0, err 0; op_count=1 after resp0_ready.
REQ-035 Both requesters valid from reset (req0 sub 5-5, req1 or 3|4): req0 served first (result 0, zero 1), then req1 (result 7); third tie after that goes to req0.
REQ-036 Opcode 111 from req1: resp1_valid with result 0, err 1, carry 0, zero 0; next legal op returns err 0.
REQ-037 Backpressure: resp0_ready held low 10 cycles: FSM stays in RESP, outputs stable, req1_ready stays low; the handshake then returns the FSM to IDLE.
REQ-038 rst pulsed during EXEC: no respN_valid follows, op_count unchanged, busy=0 the cycle after reset, and the next request is served normally.
REQ-039 Preload 65535 completions (or force op_count): the next handshake gives op_count=0.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end for an external ALU.
//               Only one operation is in flight at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int d_Width = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [d_Width-1:0] req0_opA,
    input  logic [d_Width-1:0] req0_opB,
    input  logic [2:0]         req0_opcode,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [d_Width-1:0] req1_opA,
    input  logic [d_Width-1:0] req1_opB,
    input  logic [2:0]         req1_opcode,
    output logic               resp0_valid,
    input  logic               resp0_ready,
    output logic               resp1_valid,
    input  logic               resp1_ready,
    output logic [d_Width-1:0] resp_result,
    output logic               resp_carry,
    output logic               resp_zero,
    output logic               resp_err,
    output logic [d_Width-1:0] alu_opA,
    output logic [d_Width-1:0] alu_opB,
    output logic [2:0]         alu_opcode,
    input  logic [d_Width-1:0] alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    output logic               busy,
    output logic [15:0]        op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_ILLEGAL = 3'b111;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               id_q, id_d;
    logic [d_Width-1:0] opa_q, opa_d;
    logic [d_Width-1:0] opb_q, opb_d;
    logic [2:0]         opc_q, opc_d;
    logic [d_Width-1:0] res_q, res_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic [15:0]        op_count_q, op_count_d;
    logic               grant_sel;
    logic               resp_hs;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        opc_d        = opc_q;
        res_d        = res_q;
        carry_d      = carry_q;
        zero_d       = zero_q;
        err_d        = err_q;
        op_count_d   = op_count_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        // On a tie the requester that was not granted last takes the slot.
        grant_sel    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        resp_hs      = id_q ? resp1_ready : resp0_ready;

        case (state_q)
            S_IDLE: begin
                if (!rst && (req0_valid || req1_valid)) begin
                    req0_ready   = ~grant_sel;
                    req1_ready   = grant_sel;
                    id_d         = grant_sel;
                    last_grant_d = grant_sel;
                    opa_d        = grant_sel ? req1_opA    : req0_opA;
                    opb_d        = grant_sel ? req1_opB    : req0_opB;
                    opc_d        = grant_sel ? req1_opcode : req0_opcode;
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                if (opc_q == c_OP_ILLEGAL) begin
                    res_d   = '0;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    res_d   = alu_result;
                    carry_d = alu_carry;
                    zero_d  = alu_zero;
                    err_d   = 1'b0;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_hs) begin
                    op_count_d = op_count_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            opa_q        <= '0;
            opb_q        <= '0;
            opc_q        <= 3'b000;
            res_q        <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
            op_count_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            opc_q        <= opc_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign resp0_valid = (state_q == S_RESP) && !id_q;
    assign resp1_valid = (state_q == S_RESP) &&  id_q;
    assign resp_result = res_q;
    assign resp_carry  = carry_q;
    assign resp_zero   = zero_q;
    assign resp_err    = err_q;
    assign alu_opA     = opa_q;
    assign alu_opB     = opb_q;
    assign alu_opcode  = opc_q;
    assign busy        = (state_q != S_IDLE);
    assign op_count    = op_count_q;

endmodule
`default_nettype wire
